nn_layer_sequencer: RTL and testbench
=====================================

// Module: nn_layer_sequencer
// PURPOSE
//  Top-level layer scheduler for the network datapath. On a single go request it runs layers
//  0..num_layers-1 in order. For each layer it pulses the RAM read driver, waits for the
//  driver's sum_trigger completion, then hands off to the activation/accumulate stage and waits
//  for its done. It produces a single done pulse, or a sticky error on watchdog timeout or on an
//  illegal layer count.
// PARAMETERS
//  LAYER_W   2     width of layer index / layer count
//  MAX_LYR   3     highest legal num_layers (read driver maps only layers 0..2)
//  TIMEOUT   1024  max cycles spent in any wait state before error
//  CNT_W     11    watchdog counter width; must hold TIMEOUT
// PORTS
//  clk         in   1        clock; all state updates on posedge
//  reset       in   1        synchronous, active-high reset
//  go          in   1        start request, sampled only in IDLE
//  num_layers  in   LAYER_W  layers to run, sampled with go; legal 1..MAX_LYR
//  clear_err   in   1        clears sticky err, returns ERR->IDLE
//  drv_start   out  1        1-cycle start pulse to RAM read driver
//  drv_layer   out  LAYER_W  layer index to read driver; stable from ISSUE through DRAIN
//  drv_sum     in   1        read driver sum_trigger (held high 2 cycles at end of layer)
//  act_start   out  1        1-cycle start pulse to activation stage
//  act_done    in   1        activation stage completion, level or pulse
//  busy        out  1        high in every state except IDLE and ERR
//  done        out  1        1-cycle pulse after last layer completes
//  err         out  1        sticky error flag
//  err_code    out  2        0 none, 1 bad num_layers, 2 driver timeout, 3 activation timeout
// BEHAVIOUR
//  Reset: state=IDLE, layer=0, n_lyr=0, wdog=0, sum_q=0. All outputs 0 (drv_layer=0, err_code=0).
//  Reset mid-run aborts at once; no done, no err.
//  Outputs are Moore-decoded from the state register: drv_start=(ISSUE), act_start=(ACT),
//  done=(FIN), err=(ERR). drv_layer=layer register.
//  sum_q registers drv_sum every cycle; sum_rise=drv_sum & ~sum_q.
//  States/transitions:
//   IDLE:  go & num_layers in 1..MAX_LYR -> ISSUE, layer<=0, n_lyr<=num_layers.
//          go & illegal count -> ERR, err_code<=1.
//          go low -> stay.
//   ISSUE: one cycle -> WAIT_SUM, wdog<=0.
//   WAIT_SUM: sum_rise -> DRAIN.
//          else wdog==TIMEOUT-1 -> ERR, err_code<=2.
//          else wdog++.
//   DRAIN: wait drv_sum==0, so the driver is back in its idle state -> ACT.
//          Both sum_trigger cycles yield exactly one act_start.
//   ACT:   one cycle -> WAIT_ACT, wdog<=0.
//   WAIT_ACT: act_done -> NEXT.
//          else wdog==TIMEOUT-1 -> ERR, err_code<=3.
//          else wdog++.
//   NEXT:  layer==n_lyr-1 -> FIN.
//          else layer<=layer+1 -> ISSUE.
//   FIN:   one cycle (done=1) -> IDLE. layer holds last value until the next go.
//   ERR:   hold. clear_err -> IDLE, err_code<=0.
//          Reset also clears. go is ignored in ERR.
//  go while busy: ignored, no restart. go held high after FIN: a new run starts the cycle after
//  returning to IDLE.
//  act_done or drv_sum outside their wait states: ignored.
//  clear_err outside ERR: ignored.
//  Latency: go@N -> drv_start@N+1. Driver sum rise@M -> act_start@>=M+2. act_done@K -> next
//  drv_start@K+2, or done@K+2 on the last layer.
//  Watchdog counts only in WAIT_SUM and WAIT_ACT. It never wraps: the exit is at TIMEOUT-1.
// TESTING
//  T1 num_layers=1, go 1 cycle, driver model sum after 40 cycles, act_done 5 cycles after
//     act_start -> one drv_start (layer 0), one act_start, done 1 cycle, busy low afterwards.
//  T2 num_layers=3 -> drv_layer sequence 0,1,2, three drv_start and three act_start pulses,
//     single done, no err.
//  T3 num_layers=0, then separately num_layers=3 with MAX_LYR=2 -> err=1, err_code=1, no
//     drv_start. clear_err -> IDLE, err=0.
//  T4 driver never raises sum -> err_code=2 exactly TIMEOUT cycles after entering WAIT_SUM.
//     Repeat with act_done never arriving -> err_code=3.
//  T5 drv_sum held high 2 cycles, and go re-pulsed mid-run -> exactly one act_start per layer,
//     run not restarted, done only once.
//  T6 reset asserted during WAIT_ACT of layer 1 -> next cycle all outputs 0, state IDLE; a
//     following go runs cleanly from layer 0.

Source files
------------

// File: rtl/nn_layer_sequencer.sv
// -----------------------------------------------------------------------------
// nn_layer_sequencer
//
// Top-level layer scheduler for the network datapath. One go request runs
// layers 0..num_layers-1 in order. Each layer goes through the same steps:
//   1. Pulse the RAM read driver.
//   2. Wait for the rising edge of the driver's sum_trigger.
//   3. Wait for sum_trigger to drop.
//   4. Pulse the activation/accumulate stage and wait for its done.
// At the end of the run it gives a single done pulse. A watchdog timeout or an
// illegal layer count instead sets a sticky error, which stays until clear_err.
//
// Ports
//   clk         clock; all state updates on the rising edge
//   reset       synchronous, active-high reset
//   go          start request, sampled only while idle
//   num_layers  number of layers to run, sampled with go (legal 1..MAX_LYR)
//   clear_err   leaves the error state and clears err_code
//   drv_start   1-cycle start pulse to the RAM read driver
//   drv_layer   layer index presented to the read driver
//   drv_sum     read driver sum_trigger (high for up to 2 cycles)
//   act_start   1-cycle start pulse to the activation stage
//   act_done    activation stage completion, level or pulse
//   busy        high while a run is in progress
//   done        1-cycle pulse after the last layer completes
//   err         sticky error flag
//   err_code    0 none, 1 bad num_layers, 2 driver timeout, 3 activation timeout
// -----------------------------------------------------------------------------
module nn_layer_sequencer #(
  parameter int LAYER_W = 2,
  parameter int MAX_LYR = 3,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               go,
  input  logic [LAYER_W-1:0] num_layers,
  input  logic               clear_err,
  output logic               drv_start,
  output logic [LAYER_W-1:0] drv_layer,
  input  logic               drv_sum,
  output logic               act_start,
  input  logic               act_done,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [1:0]         err_code
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_SUM,
    S_DRAIN,
    S_ACT,
    S_WAIT_ACT,
    S_NEXT,
    S_FIN,
    S_ERR
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_COUNT = 2'd1,
    ERR_DRV   = 2'd2,
    ERR_ACT   = 2'd3
  } err_code_t;

  localparam int NUM_CODES = 1 << LAYER_W;

  // Lookup of which num_layers encodings are legal. The table is built at
  // elaboration, so the run-time check is a single bit select. This also
  // works when MAX_LYR covers every encoding of num_layers.
  function automatic logic [NUM_CODES-1:0] legal_counts();
    logic [NUM_CODES-1:0] map;
    map = '0;
    for (int i = 1; i < NUM_CODES; i++) begin
      map[i] = (i <= MAX_LYR);
    end
    return map;
  endfunction

  localparam logic [NUM_CODES-1:0] LEGAL     = legal_counts();
  localparam logic [CNT_W-1:0]     WDOG_LAST = CNT_W'(TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [LAYER_W-1:0] layer_q, layer_d;
  logic [LAYER_W-1:0] n_lyr_q, n_lyr_d;
  logic [CNT_W-1:0]   wdog_q, wdog_d;
  err_code_t          code_q, code_d;
  logic               sum_q;
  logic               sum_rise;

  // Only a fresh rising edge of sum_trigger counts. If sum_trigger is still
  // high from an earlier layer, it does not end the wait.
  assign sum_rise = drv_sum & ~sum_q;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the clock edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      layer_q <= '0;
      n_lyr_q <= '0;
      wdog_q  <= '0;
      code_q  <= ERR_NONE;
      sum_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
      n_lyr_q <= n_lyr_d;
      wdog_q  <= wdog_d;
      code_q  <= code_d;
      sum_q   <= drv_sum;
    end
  end

  // NOTE: every signal written here gets a hold-value default first. Without
  // that, any path that skips an assignment would infer a latch.
  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    n_lyr_d = n_lyr_q;
    wdog_d  = wdog_q;
    code_d  = code_q;

    unique case (state_q)
      S_IDLE: begin
        if (go) begin
          if (LEGAL[num_layers]) begin
            state_d = S_ISSUE;
            layer_d = '0;
            n_lyr_d = num_layers;
          end else begin
            state_d = S_ERR;
            code_d  = ERR_COUNT;
          end
        end
      end

      S_ISSUE: begin
        state_d = S_WAIT_SUM;
        wdog_d  = '0;
      end

      // The watchdog exits at TIMEOUT-1, so the counter never wraps.
      S_WAIT_SUM: begin
        if (sum_rise) begin
          state_d = S_DRAIN;
        end else if (wdog_q == WDOG_LAST) begin
          state_d = S_ERR;
          code_d  = ERR_DRV;
        end else begin
          wdog_d = wdog_q + CNT_W'(1);
        end
      end

      // Hold here until the driver has dropped sum_trigger and is back in
      // idle. A two-cycle trigger therefore yields only one act_start.
      S_DRAIN: begin
        if (!drv_sum) begin
          state_d = S_ACT;
        end
      end

      S_ACT: begin
        state_d = S_WAIT_ACT;
        wdog_d  = '0;
      end

      S_WAIT_ACT: begin
        if (act_done) begin
          state_d = S_NEXT;
        end else if (wdog_q == WDOG_LAST) begin
          state_d = S_ERR;
          code_d  = ERR_ACT;
        end else begin
          wdog_d = wdog_q + CNT_W'(1);
        end
      end

      S_NEXT: begin
        if (layer_q == n_lyr_q - LAYER_W'(1)) begin
          state_d = S_FIN;
        end else begin
          layer_d = layer_q + LAYER_W'(1);
          state_d = S_ISSUE;
        end
      end

      // layer_q keeps the last layer index until the next go.
      S_FIN: begin
        state_d = S_IDLE;
      end

      S_ERR: begin
        if (clear_err) begin
          state_d = S_IDLE;
          code_d  = ERR_NONE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Moore outputs decoded straight from the state register.
  assign drv_start = (state_q == S_ISSUE);
  assign act_start = (state_q == S_ACT);
  assign done      = (state_q == S_FIN);
  assign err       = (state_q == S_ERR);
  assign busy      = (state_q != S_IDLE) && (state_q != S_ERR);
  assign drv_layer = layer_q;
  assign err_code  = code_q;

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// -----------------------------------------------------------------------------
// tb_nn_layer_sequencer
//
// Self-checking bench for nn_layer_sequencer.
//
// The reference model works at the level of whole runs. It does not step
// through states. For each layer it draws the random driver and activation
// delays, then derives every expected event cycle from the documented
// latencies:
//   drv_start  = go + 1, or previous act_done + 2
//   act_start  = sum rise + 1 + hold length
//   done       = last act_done + 2
// Outputs are compared every cycle against that schedule.
//
// A second instance uses MAX_LYR=2 and a short watchdog. It covers the
// illegal-count case for that configuration and the timeout boundary.
// -----------------------------------------------------------------------------
module tb_nn_layer_sequencer;

  localparam int LAYER_W = 2;
  localparam int MAX_LYR = 3;
  localparam int TIMEOUT = 1024;
  localparam int CNT_W   = 11;
  localparam int B_TMO   = 8;

  logic               clk = 1'b0;
  logic               reset;
  logic               go;
  logic [LAYER_W-1:0] num_layers;
  logic               clear_err;
  logic               drv_start;
  logic [LAYER_W-1:0] drv_layer;
  logic               drv_sum;
  logic               act_start;
  logic               act_done;
  logic               busy;
  logic               done;
  logic               err;
  logic [1:0]         err_code;

  logic               b_reset;
  logic               b_go;
  logic [LAYER_W-1:0] b_num;
  logic               b_clear;
  logic               b_drv_start;
  logic [LAYER_W-1:0] b_drv_layer;
  logic               b_act_start;
  logic               b_busy;
  logic               b_done;
  logic               b_err;
  logic [1:0]         b_err_code;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_layer = 0;

  nn_layer_sequencer #(
    .LAYER_W(LAYER_W), .MAX_LYR(MAX_LYR), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .go(go), .num_layers(num_layers),
    .clear_err(clear_err), .drv_start(drv_start), .drv_layer(drv_layer),
    .drv_sum(drv_sum), .act_start(act_start), .act_done(act_done),
    .busy(busy), .done(done), .err(err), .err_code(err_code)
  );

  nn_layer_sequencer #(
    .LAYER_W(LAYER_W), .MAX_LYR(2), .TIMEOUT(B_TMO), .CNT_W(4)
  ) dut_b (
    .clk(clk), .reset(b_reset), .go(b_go), .num_layers(b_num),
    .clear_err(b_clear), .drv_start(b_drv_start), .drv_layer(b_drv_layer),
    .drv_sum(1'b0), .act_start(b_act_start), .act_done(1'b0),
    .busy(b_busy), .done(b_done), .err(b_err), .err_code(b_err_code)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation still running at cycle %0d, limit 5000000 time units", cyc);
    $fatal(1);
  end

  typedef struct {
    int n;
    int d_fix;
    int a_fix;
    bit hold2;
    bit act_level;
    bit go_mid;
    bit chain;
    int exp_drv;
    int exp_act;
    int exp_done;
  } vec_t;

  // Output vector: {drv_start, drv_layer, act_start, busy, done, err, err_code}
  function automatic logic [8:0] obs();
    return {drv_start, drv_layer, act_start, busy, done, err, err_code};
  endfunction

  function automatic logic [8:0] obs_b();
    return {b_drv_start, b_drv_layer, b_act_start, b_busy, b_done, b_err, b_err_code};
  endfunction

  function automatic logic [8:0] pack(input bit ds, input int lay, input bit as,
                                     input bit bz, input bit dn, input bit er,
                                     input int code);
    return {ds, LAYER_W'(lay), as, bz, dn, er, 2'(code)};
  endfunction

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int k);
    for (int j = 0; j < k; j++) begin
      check($sformatf("idle cyc=%0d", cyc), 32'(obs()),
            32'(pack(0, last_layer, 0, 0, 0, 0, 0)));
      go        = 1'b0;
      clear_err = 1'(($urandom % 2));
      drv_sum   = 1'(($urandom % 2));
      act_done  = 1'(($urandom % 2));
      num_layers = LAYER_W'($urandom);
      step();
    end
    drv_sum  = 1'b0;
    act_done = 1'b0;
  endtask

  // One legal run. The schedule of input and output events is derived up
  // front from the documented latencies, then applied and checked every cycle.
  task automatic run_legal(input int n, input int d_fix, input int a_fix,
                           input bit hold2, input bit act_level, input bit go_mid,
                           input bit chain, input bit abort,
                           output int n_drv, output int n_act, output int n_done);
    int s[MAX_LYR];
    int m[MAX_LYR];
    int h[MAX_LYR];
    int a[MAX_LYR];
    int k[MAX_LYR];
    int sp_act[MAX_LYR];
    int sp_sum[MAX_LYR];
    int n0, d_end, g_mid, c_last, e_lay;
    bit e_ds, e_as, sum_v, act_v;

    n0   = cyc;
    s[0] = n0 + 1;
    for (int i = 0; i < n; i++) begin
      if (i > 0) s[i] = k[i-1] + 2;
      m[i] = s[i] + ((d_fix > 0) ? d_fix : int'($urandom_range(1, 40)));
      h[i] = hold2 ? 2 : 1;
      a[i] = m[i] + 1 + h[i];
      k[i] = a[i] + ((a_fix > 0) ? a_fix : int'($urandom_range(1, 8)));
      sp_act[i] = (m[i] - s[i] >= 2) ? int'($urandom_range(s[i] + 1, m[i] - 1)) : -1;
      sp_sum[i] = (k[i] - a[i] >= 2) ? int'($urandom_range(a[i] + 1, k[i] - 1)) : -1;
    end
    d_end  = k[n-1] + 2;
    g_mid  = go_mid ? int'($urandom_range(s[0] + 1, d_end - 1)) : -1;
    c_last = abort ? a[1] + 1 : d_end;
    n_drv  = 0;
    n_act  = 0;
    n_done = 0;

    while (cyc <= c_last) begin
      e_lay = last_layer;
      e_ds  = 1'b0;
      e_as  = 1'b0;
      for (int i = 0; i < n; i++) begin
        if (cyc >= s[i]) e_lay = i;
        if (cyc == s[i]) e_ds = 1'b1;
        if (cyc == a[i]) e_as = 1'b1;
      end
      check($sformatf("run n=%0d cyc=%0d", n, cyc), 32'(obs()),
            32'(pack(e_ds, e_lay, e_as, (cyc >= s[0]) && (cyc <= d_end),
                     cyc == d_end, 0, 0)));
      n_drv  += int'(drv_start);
      n_act  += int'(act_start);
      n_done += int'(done);

      sum_v = 1'b0;
      act_v = 1'b0;
      for (int i = 0; i < n; i++) begin
        if (cyc >= m[i] && cyc < m[i] + h[i]) sum_v = 1'b1;
        if (cyc == sp_sum[i]) sum_v = 1'b1;
        if (cyc == k[i] || (act_level && cyc == k[i] + 1) || cyc == sp_act[i]) act_v = 1'b1;
      end
      drv_sum    = sum_v;
      act_done   = act_v;
      go         = (cyc == n0) || (cyc == g_mid) || (chain && cyc == d_end);
      num_layers = (cyc == n0) ? LAYER_W'(n) : LAYER_W'($urandom);
      clear_err  = (($urandom % 8) == 0);
      reset      = abort && (cyc == c_last);
      step();
    end
    drv_sum   = 1'b0;
    act_done  = 1'b0;
    clear_err = 1'b0;
    if (!chain) go = 1'b0;
    if (!abort) last_layer = n - 1;
  endtask

  // Illegal count: straight to ERR with code 1. go is ignored while in ERR,
  // and clear_err returns to IDLE.
  task automatic run_bad(input int n, output int n_drv);
    int n0, off;
    n0    = cyc;
    n_drv = 0;
    for (off = 0; off <= 6; off++) begin
      if (off >= 1 && off <= 5)
        check($sformatf("bad n=%0d cyc=%0d", n, cyc), 32'(obs()),
              32'(pack(0, last_layer, 0, 0, 0, 1, 1)));
      else
        check($sformatf("bad n=%0d cyc=%0d", n, cyc), 32'(obs()),
              32'(pack(0, last_layer, 0, 0, 0, 0, 0)));
      n_drv     += int'(drv_start);
      go         = (off == 0) || (off == 3);
      num_layers = (off == 0) ? LAYER_W'(n) : LAYER_W'(1);
      clear_err  = (off == 5);
      step();
    end
    go        = 1'b0;
    clear_err = 1'b0;
  endtask

  // The watchdog fires exactly TIMEOUT cycles after entering the wait state.
  task automatic run_timeout(input bit on_act);
    int n0, s0, m0, a0, e_err, code;
    n0    = cyc;
    s0    = n0 + 1;
    m0    = s0 + 3;
    a0    = m0 + 2;
    e_err = on_act ? a0 + 1 + TIMEOUT : s0 + 1 + TIMEOUT;
    code  = on_act ? 3 : 2;
    while (cyc <= e_err + 1) begin
      check($sformatf("timeout code=%0d cyc=%0d", code, cyc), 32'(obs()),
            32'(pack(cyc == s0, (cyc == n0) ? last_layer : 0,
                     on_act && (cyc == a0),
                     (cyc >= s0) && (cyc < e_err), 0,
                     cyc == e_err, (cyc == e_err) ? code : 0)));
      go         = (cyc == n0) || (cyc == s0 + 2);
      num_layers = LAYER_W'(2);
      drv_sum    = on_act && (cyc == m0);
      act_done   = !on_act && (($urandom % 4) == 0);
      clear_err  = (cyc == e_err) || (cyc == s0 + 4);
      step();
    end
    go         = 1'b0;
    clear_err  = 1'b0;
    drv_sum    = 1'b0;
    act_done   = 1'b0;
    last_layer = 0;
  endtask

  // Second instance (MAX_LYR=2, watchdog 8): num_layers=3 is rejected; a
  // legal run with no driver response times out on the 8th wait cycle.
  task automatic run_b();
    logic [8:0] e;
    for (int off = 0; off <= 14; off++) begin
      if (off == 1 || off == 2)    e = pack(0, 0, 0, 0, 0, 1, 1);
      else if (off == 4)           e = pack(1, 0, 0, 1, 0, 0, 0);
      else if (off >= 5 && off < 5 + B_TMO) e = pack(0, 0, 0, 1, 0, 0, 0);
      else if (off >= 5 + B_TMO)   e = pack(0, 0, 0, 0, 0, 1, 2);
      else                         e = pack(0, 0, 0, 0, 0, 0, 0);
      check($sformatf("b off=%0d", off), 32'(obs_b()), 32'(e));
      b_go    = (off == 0) || (off == 1) || (off == 3);
      b_num   = (off == 0) ? LAYER_W'(3) : LAYER_W'(2);
      b_clear = (off == 2);
      step();
    end
    b_go = 1'b0;
  endtask

  vec_t tbl[8];

  initial begin
    int nd, na, nf;
    vec_t v;

    tbl[0] = '{1, 40, 5, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1, 1};
    tbl[1] = '{3,  0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 3, 3, 1};
    tbl[2] = '{0,  0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0};
    tbl[3] = '{2,  0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 2, 2, 1};
    tbl[4] = '{3,  0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 3, 3, 1};
    tbl[5] = '{1,  1, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1, 1};
    tbl[6] = '{2,  0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 2, 2, 1};
    tbl[7] = '{3,  1, 1, 1'b1, 1'b1, 1'b0, 1'b0, 3, 3, 1};

    reset = 1'b1; go = 1'b1; num_layers = LAYER_W'(1); clear_err = 1'b0;
    drv_sum = 1'b0; act_done = 1'b0;
    b_reset = 1'b1; b_go = 1'b0; b_num = '0; b_clear = 1'b0;
    step();
    check("reset_first", 32'(obs()), 32'(0));
    step();
    check("reset_hold_go", 32'(obs()), 32'(0));
    check("b_reset", 32'(obs_b()), 32'(0));
    reset = 1'b0; go = 1'b0; b_reset = 1'b0;
    step();

    run_b();
    idle(2);

    foreach (tbl[i]) begin
      v = tbl[i];
      if (v.n >= 1 && v.n <= MAX_LYR) begin
        run_legal(v.n, v.d_fix, v.a_fix, v.hold2, v.act_level, v.go_mid,
                  v.chain, 1'b0, nd, na, nf);
      end else begin
        run_bad(v.n, nd);
        na = 0;
        nf = 0;
      end
      check($sformatf("vec%0d drv_starts", i), 32'(nd), 32'(v.exp_drv));
      check($sformatf("vec%0d act_starts", i), 32'(na), 32'(v.exp_act));
      check($sformatf("vec%0d dones", i), 32'(nf), 32'(v.exp_done));
      if (!v.chain) idle(int'($urandom_range(0, 3)));
    end

    run_timeout(1'b0);
    idle(2);
    run_timeout(1'b1);
    idle(2);

    // Reset in the WAIT_ACT of layer 1 clears everything on the next cycle.
    run_legal(3, 0, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, nd, na, nf);
    check("abort_all_zero", 32'(obs()), 32'(0));
    reset = 1'b0;
    last_layer = 0;
    step();
    idle(2);
    run_legal(2, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, nd, na, nf);
    check("after_abort drv_starts", 32'(nd), 32'(2));
    check("after_abort dones", 32'(nf), 32'(1));
    idle(1);

    for (int r = 0; r < 8; r++) begin
      int n;
      bit g2;
      n  = int'($urandom_range(1, MAX_LYR));
      g2 = 1'(($urandom % 2));
      run_legal(n, 0, 0, 1'(($urandom % 2)), 1'(($urandom % 2)), g2, 1'b0, 1'b0,
                nd, na, nf);
      check($sformatf("rand%0d drv_starts", r), 32'(nd), 32'(n));
      check($sformatf("rand%0d act_starts", r), 32'(na), 32'(n));
      check($sformatf("rand%0d dones", r), 32'(nf), 32'(1));
      idle(int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
